stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 106 ++++++++++
 tb/tb_stall_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: merges ID/EX stall requests with a fixed-latency
// divider sequence and counts stalled cycles.
module stall_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        div_start,
  input  logic        div_annul,
  input  logic        flush,
  output logic [5:0]  stall,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] stall_cnt,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(DIV_CYCLES - 1);

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Flush and annul abort from any state; a start outside IDLE is ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush || div_annul) begin
      state_nxt = IDLE;
      cnt_nxt   = 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            state_nxt = DIV_RUN;
            cnt_nxt   = 6'd0;
          end
        end
        DIV_RUN: begin
          if (cnt == LAST_CNT) begin
            state_nxt = DIV_DONE;
            cnt_nxt   = 6'd0;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
        DIV_DONE: begin
          state_nxt = IDLE;
          cnt_nxt   = 6'd0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 6'd0;
        end
      endcase
    end
  end

  // Outputs are held quiet while reset is low, whatever the inputs do.
  always_comb begin
    stall    = 6'b000000;
    div_busy = 1'b0;
    div_done = 1'b0;
    if (rst) begin
      div_busy = (state == DIV_RUN);
      div_done = (state == DIV_DONE) && !flush && !div_annul;
      if (flush) begin
        stall = 6'b000000;
      end else if ((state == DIV_RUN) || ((state == IDLE) && div_start)) begin
        stall = 6'b001111;
      end else if (stallreq_ex) begin
        stall = 6'b001111;
      end else if (stallreq_id) begin
        stall = 6'b000111;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
    end else if (stall[0] && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: per-cycle expected {stall,busy,done}
// values are queued when stimulus is driven and compared at the falling edge.
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        div_start = 1'b0;
  logic        div_annul = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  stall;
  logic        div_busy;
  logic        div_done;
  logic [31:0] stall_cnt;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [7:0] got_v;

  stall_ctrl #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .div_start(div_start), .div_annul(div_annul), .flush(flush),
    .stall(stall), .div_busy(div_busy), .div_done(div_done),
    .stall_cnt(stall_cnt), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic id, input logic ex, input logic start,
                       input logic annul, input logic fl);
    stallreq_id = id;
    stallreq_ex = ex;
    div_start   = start;
    div_annul   = annul;
    flush       = fl;
  endtask

  task automatic push_exp(input logic [5:0] s, input logic b, input logic d);
    exp_q.push_back({s, b, d});
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1, 1, 1, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, div_busy, div_done} !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {stall, div_busy, div_done}, 8'd0);
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d exp=0", stall_cnt);
    end
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 0, 0);
      push_exp(6'b000000, 1'b0, 1'b0);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {stall, div_busy, div_done};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL idle c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL idle_cnt got=%0d exp=0", stall_cnt);
    end
  endtask

  task automatic test_divide();
    apply_reset();
    for (int c = 0; c < 36; c++) begin
      drive(0, 0, c == 0, 0, 0);
      push_exp((c <= 32) ? 6'b001111 : 6'b000000, (c >= 1 && c <= 32), c == 33);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {stall, div_busy, div_done};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL divide c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 32'd33) begin
      failures++;
      $display("FAIL divide_cnt got=%0d exp=33", stall_cnt);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int c = 0; c < 50; c++) begin
      drive(0, 0, (c == 0) || (c == 12), 0, c == 10);
      push_exp((c <= 9 || (c >= 12 && c <= 44)) ? 6'b001111 : 6'b000000,
               (c >= 1 && c <= 10) || (c >= 13 && c <= 44), c == 45);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {stall, div_busy, div_done};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL flush c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 32'd43) begin
      failures++;
      $display("FAIL flush_cnt got=%0d exp=43", stall_cnt);
    end
  endtask

  task automatic test_requests();
    logic [2:0]  tbl_in [5] = '{3'b110, 3'b100, 3'b010, 3'b111, 3'b000};
    logic [5:0]  tbl_st [5] = '{6'b001111, 6'b000111, 6'b001111, 6'b000000, 6'b000000};
    int unsigned exp_cnt = 0;
    logic id, ex;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      drive(tbl_in[c][2], tbl_in[c][1], 0, 0, tbl_in[c][0]);
      push_exp(tbl_st[c], 1'b0, 1'b0);
      if (tbl_st[c][0]) exp_cnt++;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {stall, div_busy, div_done};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL req_table c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 20; c++) begin
      id = 1'($urandom_range(0, 1));
      ex = 1'($urandom_range(0, 1));
      drive(id, ex, 0, 0, 0);
      push_exp(ex ? 6'b001111 : (id ? 6'b000111 : 6'b000000), 1'b0, 1'b0);
      if (id || ex) exp_cnt++;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {stall, div_busy, div_done};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL req_rand c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL req_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    // Restart pulse ignored; reset at cycle 20 kills the divide.
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      drive(0, 0, (c == 0) || (c == 5), 0, 0);
      push_exp(6'b001111, c >= 1, 1'b0);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {stall, div_busy, div_done};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL restart c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    drive(1, 1, 1, 0, 0);
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, div_busy, div_done, stall_cnt} !== 40'd0) begin
      failures++;
      $display("FAIL midreset got=%b/%0d exp=0/0", {stall, div_busy, div_done}, stall_cnt);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      push_exp(6'b000000, 1'b0, 1'b0);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {stall, div_busy, div_done};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL postreset c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    // Start on first edge after release; ex in DIV_DONE; then annul in DIV_DONE.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 69; c++) begin
      drive(0, c == 33, (c == 0) || (c == 34), c == 67, 0);
      push_exp((c <= 32 || c == 33 || (c >= 34 && c <= 66)) ? 6'b001111 : 6'b000000,
               (c >= 1 && c <= 32) || (c >= 35 && c <= 66), c == 33);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {stall, div_busy, div_done};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 32'd67) begin
      failures++;
      $display("FAIL b2b_cnt got=%0d exp=67", stall_cnt);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt;
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL sat_preload got=%h exp=fffffffe", stall_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 0, 0);
      @(posedge clk); #1;
      checks++;
      if (stall_cnt !== 32'hFFFF_FFFF) begin
        failures++;
        $display("FAIL sat c=%0d got=%h exp=ffffffff", c, stall_cnt);
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_divide();
    test_flush();
    test_requests();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
